// File: rtl/uart_tx.sv
// uart_tx: byte FIFO in front of an LSB-first 8N1 serializer driving txd from a flop.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (11-bit frame).
module uart_tx #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rstd,
    input  logic [7:0] uart,
    input  logic       uart_we,
    output logic       txd,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W        = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic [7:0] fifo_mem [FIFO_DEPTH];
    logic       push;
    logic       pop;
    logic       baud_done;

    // FIFO bookkeeping; full is taken from the registered state, so a write racing a pop while full is dropped
    always_comb begin : fifo_next
        push       = uart_we && !full_q;
        pop        = (state_q == S_IDLE) && (count_q != '0);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d     = (count_d == CNT_FULL);
        overflow_d = overflow_q || (uart_we && full_q);
    end

    // Frame sequencing; the baud counter restarts on every state change
    always_comb begin : fsm_next
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        baud_done = (baud_q == BAUD_LAST);

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d  = fifo_mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_mem[rd_ptr_q];
`endif
                    baud_d   = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        // Line level follows the next state so txd and state change on the same edge
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = parity_d;
`endif
            default:  txd_d = 1'b1;
        endcase

        busy_d = (count_d != '0) || (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin : regs
        if (rstd) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Storage array needs no reset: entries are only read once the count says they are valid
    always_ff @(posedge clk) begin : fifo_store
        if (push) begin
            fifo_mem[wr_ptr_q] <= uart;
        end
    end

    assign txd       = txd_q;
    assign busy      = busy_q;
    assign fifo_full = full_q;
    assign overflow  = overflow_q;

endmodule
